seg7_scan_driver: RTL



---
 rtl/seg7_scan_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for an NDIGITS-digit 7-segment display.
// A frame-synchronised display copy is scanned one digit per slot, with a dead cycle between slots.
module seg7_scan_driver #(
  parameter int NDIGITS        = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic [NDIGITS-1:0]     blink_en,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]         SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic               DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NDIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [BW-1:0]          bcnt;
  logic                   bphase;
  logic [4*NDIGITS-1:0]   stg_val;
  logic [NDIGITS-1:0]     stg_dp;
  logic [4*NDIGITS-1:0]   disp_val;
  logic [NDIGITS-1:0]     disp_dp;

  logic                   tick;
  logic                   frame_end;
  logic [NDIGITS-1:0]     lz_mask;
  logic                   upper_zero;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_lz;
  logic                   cur_blink;
  logic [NDIGITS-1:0]     an_hot;
  logic                   cur_blank;

  assign tick      = (presc == PW'(CLK_DIV - 1));
  assign frame_end = tick && (idx == IW'(NDIGITS - 1));

  // Scan timing: prescaler, digit index, blink frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= '0;
      bcnt   <= '0;
      bphase <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
      if (frame_end) begin
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt   <= '0;
          bphase <= ~bphase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // Staging takes every load; the display copy only changes at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_val  <= '0;
      stg_dp   <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        stg_val <= value;
        stg_dp  <= dp_in;
      end
      if (frame_end) begin
        disp_val <= load ? value : stg_val;
        disp_dp  <= load ? dp_in : stg_dp;
      end
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (disp_val[4*i +: 4] == 4'h0);
      lz_mask[i] = blank_lz & upper_zero;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_lz    = lz_mask[i];
        cur_blink = blink_en[i];
        an_hot[i] = 1'b1;
      end
    end
  end

  assign cur_blank = (cur_blink & bphase) | cur_lz;

  // Output register stage; prescaler 0 is the dead cycle after each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else if (presc == '0) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else begin
      an  <= (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
      seg <= cur_blank ? SEG_OFF
           : ((SEG_ACTIVE_LOW != 0) ? hex_glyph(cur_nib) : ~hex_glyph(cur_nib));
      dp  <= (SEG_ACTIVE_LOW != 0) ? ~(cur_dp & ~cur_blank) : (cur_dp & ~cur_blank);
    end
  end

endmodule
